dmem_arbiter: RTL

Two-port arbiter and access sequencer for the single-cycle processor's word-addressed data memory. It accepts load/store requests from two requesters: port 0 is the CPU datapath, port 1 is a loader/debug master. It grants one request at a time by round-robin and drives the memory's address, write-data, write-enable and read-enable for a fixed number of access cycles. It then returns registered read data with a one-cycle done pulse, and rejects misaligned or out-of-range addresses without touching memory.

---
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port round-robin arbiter and access sequencer for the word-addressed
//   data memory. Port 0 is the CPU datapath and port 1 is the loader/debug
//   master. A granted request is latched, checked, and then either played to
//   the memory for ACCESS_CYCLES cycles or rejected without touching memory.
//
// Parameters
//   DEPTH          memory size in 32-bit words (byte range 0 .. DEPTH*4-1)
//   ACCESS_CYCLES  cycles the memory strobes are held per access (1..15)
//
// Ports
//   clock, reset                 rising-edge clock, async active-high reset
//   req0/1, we0/1                request valid, 1 = store / 0 = load
//   addr0/1, wdata0/1            byte address and store data
//   gnt0/1                       one-cycle pulse: request accepted and latched
//   done0/1, err0/1              one-cycle completion pulse, error qualifier
//   rdata                        load result, valid with done, held otherwise
//   mem_address, mem_writeData   memory address / write data
//   mem_memWrite, mem_memRead    memory strobes, decoded from registered state
//   mem_readData                 combinational read data from the memory
module dmem_arbiter #(
  parameter int DEPTH         = 128,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_memWrite,
  output logic        mem_memRead,
  input  logic [31:0] mem_readData
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;
  // A rejected request spends its gnt cycle here so that done/err follow one
  // cycle after gnt, the same spacing a single-cycle access has.
  localparam logic [1:0] BADWAIT = 2'd3;

  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);
  localparam logic [3:0]  CNT_LAST   = 4'(ACCESS_CYCLES - 1);

  logic [1:0]  state;
  logic        own;
  logic        last;
  logic [3:0]  cnt;
  logic        latWe;
  logic        latBad;
  logic [31:0] latAddr;
  logic [31:0] latWdata;
  logic [1:0]  gntQ;
  logic [31:0] rdataQ;

  logic        anyReq;
  logic        pick;
  logic        selWe;
  logic [31:0] selAddr;
  logic [31:0] selWdata;
  logic        selBad;
  logic        cntLast;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    anyReq   = req0 | req1;
    // On a tie the port that did not win last time is chosen.
    pick     = (req0 && req1) ? ~last : req1;
    selWe    = pick ? we1 : we0;
    selAddr  = pick ? addr1 : addr0;
    selWdata = pick ? wdata1 : wdata0;
    selBad   = (selAddr[1:0] != 2'b00) || (selAddr >= ADDR_LIMIT);
    cntLast  = (cnt == CNT_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      own      <= 1'b0;
      last     <= 1'b1;
      cnt      <= 4'd0;
      latWe    <= 1'b0;
      latBad   <= 1'b0;
      latAddr  <= 32'd0;
      latWdata <= 32'd0;
      gntQ     <= 2'b00;
      rdataQ   <= 32'd0;
    end else begin
      gntQ <= 2'b00;
      case (state)
        IDLE: begin
          if (anyReq) begin
            own    <= pick;
            last   <= pick;
            cnt    <= 4'd0;
            gntQ   <= pick ? 2'b10 : 2'b01;
            latWe  <= selWe;
            latBad <= selBad;
            if (selBad) begin
              state <= BADWAIT;
            end else begin
              // Address/data registers load only for accesses that reach the
              // memory, so mem_address holds across rejected requests.
              latAddr  <= selAddr;
              latWdata <= selWdata;
              state    <= ACCESS;
            end
          end
        end
        BADWAIT: begin
          rdataQ <= 32'd0;
          state  <= DONE;
        end
        ACCESS: begin
          cnt <= cnt + 4'd1;
          if (cntLast) begin
            if (!latWe) rdataQ <= mem_readData;
            state <= DONE;
          end
        end
        default: state <= IDLE;  // DONE: requests are not sampled here
      endcase
    end
  end

  assign gnt0          = gntQ[0];
  assign gnt1          = gntQ[1];
  assign done0         = (state == DONE) && !own;
  assign done1         = (state == DONE) && own;
  assign err0          = done0 && latBad;
  assign err1          = done1 && latBad;
  assign rdata         = rdataQ;
  assign mem_address   = latAddr;
  assign mem_writeData = latWdata;
  // Strobes come straight from registered state; the write strobe is held to
  // the final access cycle so a store produces exactly one falling-edge write.
  assign mem_memRead   = (state == ACCESS) && !latWe;
  assign mem_memWrite  = (state == ACCESS) && latWe && cntLast;

endmodule
